clk_div_prog: RTL and testbench

Programmable integer clock divider that generates a registered divided clock `out_clk`, plus single-cycle rise/fall strobes, from the system clock. It sits directly upstream of the fixed divide-by-4 stage's consumers as its general replacement, and feeds downstream logic that needs either a slow clock-like signal or clock-enable ticks in the `clk` domain. The divide ratio is changed at run time through a valid/ready handshake. A new ratio takes effect only on an output-period boundary, so no runt pulses are produced.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clkdiv_ratio_reg.sv | 49 ++++
 rtl/clk_div_prog.sv | 127 ++++++++++++
 tb/tb_clk_div_prog.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: FSM state encoding
// and the smallest ratio that still yields a high and a low phase.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_prog_if.sv
// Ratio-update handshake bundle for clk_div_prog: the requester drives the
// ratio and valid, the divider answers with ready and an illegal-ratio pulse.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;

    modport master (
        output div_in,
        output div_valid,
        input  div_ready,
        input  div_err
    );

    modport slave (
        input  div_in,
        input  div_valid,
        output div_ready,
        output div_err
    );
endinterface

// File: rtl/clkdiv_ratio_reg.sv
// Holds one accepted divide ratio until the divider reaches a point where it
// may switch ratios; ready is low exactly while a ratio is waiting.
module clkdiv_ratio_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_data,
    input  logic             i_apply,
    output logic             o_ready,
    output logic             o_err,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_pending_val
);
    import clkdiv_pkg::*;

    logic             r_pending;
    logic             r_err;
    logic [CNT_W-1:0] r_pending_val;
    logic             w_fire;
    logic             w_illegal;

    assign w_fire    = i_valid && !r_pending;
    assign w_illegal = (i_data < CNT_W'(MIN_DIV));

    // Illegal ratios are reported and dropped, so ready never falls for them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= 1'b0;
            r_pending_val <= '0;
            r_err         <= 1'b0;
        end else begin
            r_err <= w_fire && w_illegal;
            if (w_fire && !w_illegal) begin
                r_pending     <= 1'b1;
                r_pending_val <= i_data;
            end else if (r_pending && i_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_ready       = !r_pending;
    assign o_err         = r_err;
    assign o_pending     = r_pending;
    assign o_pending_val = r_pending_val;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with rise/fall strobes and glitch-free
// ratio changes. Optional feature macro: CLKDIV_PERIOD_CNT_EN (period counter).
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    clk_div_prog_if.slave div_if,
    output logic        o_out_clk,
    output logic        o_rise_tick,
    output logic        o_fall_tick,
    output logic        o_active
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0] o_period_cnt
`endif
);
    import clkdiv_pkg::*;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_high_next;
    logic [CNT_W-1:0] w_pending_val;
    logic             w_pending;
    logic             w_last;
    logic             w_apply;
    logic             w_run_next;
    logic             w_ready;
    logic             w_err;
    logic             r_out_clk;
    logic             r_rise;
    logic             r_fall;

    clkdiv_ratio_reg #(
        .CNT_W (CNT_W)
    ) u_ratio_reg (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (div_if.div_valid),
        .i_data        (div_if.div_in),
        .i_apply       (w_apply),
        .o_ready       (w_ready),
        .o_err         (w_err),
        .o_pending     (w_pending),
        .o_pending_val (w_pending_val)
    );

    assign div_if.div_ready = w_ready;
    assign div_if.div_err   = w_err;

    // A new ratio may only land while idle or exactly on a period boundary.
    assign w_last      = (r_state != ST_IDLE) && (r_cnt == r_div - CNT_W'(1));
    assign w_apply     = (r_state == ST_IDLE) || w_last;
    assign w_div_next  = (w_pending && w_apply) ? w_pending_val : r_div;
    assign w_high_next = w_div_next - (w_div_next >> 1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_last) begin
                    w_cnt_next   = '0;
                    w_state_next = i_en ? ST_RUN : ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_state_next = i_en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_run_next = (w_state_next != ST_IDLE);

    // Outputs are computed from the next count so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_out_clk <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_div     <= w_div_next;
            r_out_clk <= w_run_next && (w_cnt_next < w_high_next);
            r_rise    <= w_run_next && (w_cnt_next == '0);
            r_fall    <= w_run_next && (w_cnt_next == w_high_next);
        end
    end

    assign o_out_clk   = r_out_clk;
    assign o_rise_tick = r_rise;
    assign o_fall_tick = r_fall;
    assign o_active    = (r_state != ST_IDLE);

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= 16'd0;
        end else if (w_last) begin
            r_period_cnt <= r_period_cnt + 16'd1;
        end
    end

    assign o_period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a behavioural period model queues the
// expected outputs for every edge and each sample is compared against it.
module tb_clk_div_prog;

    typedef struct packed {
        logic [5:0]  sig;
        logic [15:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    logic en;
    logic outClk;
    logic riseTick;
    logic fallTick;
    logic active;
    logic [15:0] periodCnt;

    int    vectors;
    int    miscompares;
    int    riseSeen;
    string curTag;
    exp_t  expQ[$];

    // Behavioural model: 0 idle, 1 running, 2 finishing the last period
    int mState;
    int mPos;
    int mN;
    int mPend;
    int mPendVal;
    int mPc;

    clk_div_prog_if #(.CNT_W(8)) divBus ();

    clk_div_prog #(
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .div_if       (divBus),
        .o_out_clk    (outClk),
        .o_rise_tick  (riseTick),
        .o_fall_tick  (fallTick),
        .o_active     (active)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .o_period_cnt (periodCnt)
`endif
    );

`ifndef CLKDIV_PERIOD_CNT_EN
    assign periodCnt = 16'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obsVec();
        return {outClk, riseTick, fallTick, active, divBus.div_ready, divBus.div_err};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        mState   = 0;
        mPos     = 0;
        mN       = 4;
        mPend    = 0;
        mPendVal = 0;
        mPc      = 0;
        expQ.delete();
    endtask

    task automatic modelStep(input logic enIn, input logic validIn, input logic [7:0] dataIn);
        int   dv;
        int   high;
        bit   accept;
        bit   endOfPeriod;
        bit   applyNow;
        exp_t e;
        dv          = int'(dataIn);
        accept      = validIn && (mPend == 0);
        endOfPeriod = (mState != 0) && (mPos == mN - 1);
        applyNow    = (mPend != 0) && ((mState == 0) || endOfPeriod);
        if (mState == 0) begin
            if (enIn) begin
                mState = 1;
                mPos   = 0;
            end
        end else if (endOfPeriod) begin
            mPc    = (mPc + 1) % 65536;
            mPos   = 0;
            mState = enIn ? 1 : 0;
        end else begin
            mPos   = mPos + 1;
            mState = enIn ? 1 : 2;
        end
        if (applyNow) begin
            mN    = mPendVal;
            mPend = 0;
        end
        if (accept && dv >= 2) begin
            mPend    = 1;
            mPendVal = dv;
        end
        high     = mN - mN / 2;
        e.sig[5] = (mState != 0) && (mPos < high);
        e.sig[4] = (mState != 0) && (mPos == 0);
        e.sig[3] = (mState != 0) && (mPos == high);
        e.sig[2] = (mState != 0);
        e.sig[1] = (mPend == 0);
        e.sig[0] = accept && (dv < 2);
        e.pc     = 16'(mPc);
        expQ.push_back(e);
    endtask

    // One clock cycle: drive, predict, sample 1 time unit after the edge
    task automatic applyStimulus(input logic enIn, input logic validIn, input logic [7:0] dataIn);
        exp_t e;
        en               = enIn;
        divBus.div_valid = validIn;
        divBus.div_in    = dataIn;
        modelStep(enIn, validIn, dataIn);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput(curTag, 32'(obsVec()), 32'(e.sig));
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput({curTag, "_pcnt"}, 32'(periodCnt), 32'(e.pc));
`endif
        if (riseTick) riseSeen++;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("resetVals", 32'(obsVec()), 32'(6'b000010));
        checkOutput("resetPcnt", 32'(periodCnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        riseSeen         = 0;
        rst              = 1'b1;
        en               = 1'b0;
        divBus.div_valid = 1'b0;
        divBus.div_in    = 8'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        doReset();

        curTag = "div4";
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'd0);

        curTag = "ratio1";
        applyStimulus(1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'd0);

        curTag = "ratio5";
        applyStimulus(1'b1, 1'b1, 8'd5);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 8'd0);

        curTag = "ratio6";
        applyStimulus(1'b1, 1'b1, 8'd6);
        for (int i = 0; i < 40 && !(mN == 6 && mPos == 1 && mState == 1); i++)
            applyStimulus(1'b1, 1'b0, 8'd0);
        curTag = "drain6";
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'd0);

        curTag = "pend7";
        for (int i = 0; i < 20 && !(mState == 1 && mPos == 0); i++)
            applyStimulus(1'b1, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 8'd7);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", 32'(obsVec()), 32'(6'b000010));
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        riseSeen = 0;
        curTag   = "afterRst";
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("risesAfterRst", 32'(riseSeen), 32'd3);

        doReset();
        curTag = "idle3";
        applyStimulus(1'b0, 1'b1, 8'd3);
        curTag = "run3";
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b0, 8'd0);
`ifdef CLKDIV_PERIOD_CNT_EN
        checkOutput("pcnt10", 32'(periodCnt), 32'd10);
`endif
        curTag = "stop3";
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
